// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the SRAM port arbiter: FSM states, grant IDs, strobe bundle
// and the per-state strobe decode.
package sram_port_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 18;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned CPU_ADDR_W = 16;
    localparam int unsigned WAIT_W     = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_DONE
    } state_t;

    typedef enum logic {
        GNT_IF,
        GNT_MEM
    } gnt_t;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic dq_oe;
    } strobe_t;

    // Strobe levels the SRAM pins must show while the FSM sits in a given state.
    function automatic strobe_t strobes_for(input state_t st);
        strobe_t s;
        case (st)
            ST_RD:       s = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1, dq_oe: 1'b0};
            ST_WR_SETUP: s = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b1};
            ST_WR_PULSE: s = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0, dq_oe: 1'b1};
            ST_WR_HOLD:  s = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b1};
            default:     s = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b0};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_sram_phy.sv
// SRAM pin stage: registers strobes, address and write data; the arbiter FSM
// supplies the next-cycle values.
module sram_port_arbiter_sram_phy
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  strobe_t           strobe_nxt,
    input  logic              addr_ld,
    input  logic [ADDR_W-1:0] addr_nxt,
    input  logic              data_ld,
    input  logic [DATA_W-1:0] data_nxt,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
        end else begin
            sram_ce_n  <= strobe_nxt.ce_n;
            sram_oe_n  <= strobe_nxt.oe_n;
            sram_we_n  <= strobe_nxt.we_n;
            sram_dq_oe <= strobe_nxt.dq_oe;
            if (addr_ld) sram_addr <= addr_nxt;
            if (data_ld) sram_dq_o <= data_nxt;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM port between instruction fetch and
// load/store, sequencing read and write strobe timing and raising stall.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [CPU_ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_ready,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [CPU_ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_ready,
    output logic                  stall,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_dq_o,
    output logic                  sram_dq_oe,
    input  logic [DATA_W-1:0]     sram_dq_i,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n
);

    state_t            state, state_nxt;
    gnt_t              last_grant, grant_nxt;
    logic [WAIT_W-1:0] cnt, cnt_nxt;
    logic              mem_pend, pick_mem, addr_ld, data_ld, capture;
    logic [ADDR_W-1:0] addr_nxt;
    strobe_t           strobe_nxt;

    assign mem_pend   = mem_rd | mem_wr;
    assign stall      = (if_req & ~if_ready) | (mem_pend & ~mem_ready);
    assign strobe_nxt = strobes_for(state_nxt);

    // last_grant doubles as the owner of the access in flight; it only moves in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= GNT_IF;
            cnt        <= '0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= grant_nxt;
            cnt        <= cnt_nxt;
            if (capture) begin
                if (last_grant == GNT_IF) if_rdata  <= sram_dq_i;
                else                      mem_rdata <= sram_dq_i;
            end
            if_ready  <= (state_nxt == ST_DONE) && (last_grant == GNT_IF);
            mem_ready <= (state_nxt == ST_DONE) && (last_grant == GNT_MEM);
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = last_grant;
        cnt_nxt   = cnt;
        pick_mem  = 1'b0;
        addr_ld   = 1'b0;
        addr_nxt  = '0;
        data_ld   = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (if_req | mem_pend) begin
                    pick_mem  = mem_pend && (!if_req || last_grant == GNT_IF);
                    grant_nxt = pick_mem ? GNT_MEM : GNT_IF;
                    addr_ld   = 1'b1;
                    addr_nxt  = pick_mem ? ADDR_W'(mem_addr) : ADDR_W'(if_addr);
                    // A simultaneous rd+wr is served as a store.
                    if (pick_mem && mem_wr) begin
                        state_nxt = ST_WR_SETUP;
                        data_ld   = 1'b1;
                    end else begin
                        state_nxt = ST_RD;
                        cnt_nxt   = WAIT_W'(WAIT_CYC);
                    end
                end
            end
            ST_RD: begin
                if (cnt == '0) begin
                    state_nxt = ST_DONE;
                    capture   = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_WR_SETUP: begin
                state_nxt = ST_WR_PULSE;
                cnt_nxt   = WAIT_W'(WAIT_CYC);
            end
            ST_WR_PULSE: begin
                if (cnt == '0) state_nxt = ST_WR_HOLD;
                else           cnt_nxt   = cnt - 1'b1;
            end
            ST_WR_HOLD: state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    sram_port_arbiter_sram_phy #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_phy (
        .clk        (clk),
        .rst        (rst),
        .strobe_nxt (strobe_nxt),
        .addr_ld    (addr_ld),
        .addr_nxt   (addr_nxt),
        .data_ld    (data_ld),
        .data_nxt   (mem_wdata),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: one arbiter with WAIT_CYC=1 and one with WAIT_CYC=0, each on
// a small behavioural SRAM.
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WAIT_CYC = 1 instance
  logic        if_req = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
  logic [15:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
  logic [15:0] if_rdata, mem_rdata, sram_dq_o, sram_dq_i;
  logic        if_ready, mem_ready, stall, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [17:0] sram_addr;
  logic [15:0] sram1 [256];

  // WAIT_CYC = 0 instance
  logic        if_req0 = 1'b0, mem_rd0 = 1'b0, mem_wr0 = 1'b0;
  logic [15:0] if_addr0 = '0, mem_addr0 = '0, mem_wdata0 = '0;
  logic [15:0] if_rdata0, mem_rdata0, sram_dq_o0, sram_dq_i0;
  logic        if_ready0, mem_ready0, stall0, sram_dq_oe0, sram_ce_n0, sram_oe_n0, sram_we_n0;
  logic [17:0] sram_addr0;
  logic [15:0] sram0 [256];

  // {ce_n, oe_n, we_n, dq_oe} for SETUP, PULSE, PULSE, HOLD, DONE at WAIT_CYC=1
  logic [3:0] wr_seq [5] = '{4'b0111, 4'b0101, 4'b0101, 4'b0111, 4'b1110};

  sram_port_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYC(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  sram_port_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst),
    .if_req(if_req0), .if_addr(if_addr0), .if_rdata(if_rdata0), .if_ready(if_ready0),
    .mem_rd(mem_rd0), .mem_wr(mem_wr0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0), .mem_ready(mem_ready0), .stall(stall0),
    .sram_addr(sram_addr0), .sram_dq_o(sram_dq_o0), .sram_dq_oe(sram_dq_oe0),
    .sram_dq_i(sram_dq_i0), .sram_ce_n(sram_ce_n0), .sram_oe_n(sram_oe_n0), .sram_we_n(sram_we_n0)
  );

  assign sram_dq_i  = (!sram_ce_n  && !sram_oe_n)  ? sram1[sram_addr[7:0]]  : 16'h0000;
  assign sram_dq_i0 = (!sram_ce_n0 && !sram_oe_n0) ? sram0[sram_addr0[7:0]] : 16'h0000;

  // SRAM models: preload, then latch writes mid-cycle while WE# is low.
  initial begin
    for (int unsigned i = 0; i < 256; i++) begin
      sram1[i] = 16'h0000;
      sram0[i] = 16'h0000;
    end
    sram1[8'h04] = 16'h4A21;
    sram1[8'h20] = 16'h2020;
    sram1[8'h30] = 16'h3030;
    for (int unsigned i = 0; i < 4; i++) sram0[i] = 16'hC0D0 + 16'(i);
    forever begin
      @(negedge clk);
      if (!sram_ce_n && !sram_we_n && sram_dq_oe) sram1[sram_addr[7:0]] = sram_dq_o;
      if (!sram_ce_n0 && !sram_we_n0 && sram_dq_oe0) sram0[sram_addr0[7:0]] = sram_dq_o0;
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 1110", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe});
    end
    checks++;
    if (sram_addr !== 18'h0 || sram_dq_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_addr_data: got addr %h dq %h want 0 0", sram_addr, sram_dq_o);
    end
    checks++;
    if (if_rdata !== 16'h0 || mem_rdata !== 16'h0 || if_ready !== 1'b0 || mem_ready !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %h %h %b %b %b want 0 0 0 0 0",
               if_rdata, mem_rdata, if_ready, mem_ready, stall);
    end
    checks++;
    if (sram_ce_n0 !== 1'b1 || if_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut0: got ce_n %b ready %b want 1 0", sram_ce_n0, if_ready0);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    logic seen;
    @(negedge clk);
    mem_wr = 1'b1; mem_addr = 16'h0050; mem_wdata = 16'h1234;
    repeat (2) @(negedge clk);
    checks++;
    if (sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1) begin
      errors++;
      $display("FAIL midwr_in_pulse: got we_n %b dq_oe %b want 0 1", sram_we_n, sram_dq_oe);
    end
    #1 rst = 1'b1; mem_wr = 1'b0;
    #1;
    checks++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_ce_n !== 1'b1) begin
      errors++;
      $display("FAIL midwr_async_reset: got we_n %b dq_oe %b ce_n %b want 1 0 1",
               sram_we_n, sram_dq_oe, sram_ce_n);
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (mem_ready) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midwr_no_ready: got mem_ready pulse %b want 0", seen);
    end
  endtask

  task automatic test_fetch();
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0004;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL fetch_stall_c0: got %b want 1", stall);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (if_ready !== (k == 3) || stall !== (k != 3) || mem_ready !== 1'b0) begin
        errors++;
        $display("FAIL fetch_c%0d: got ready %b stall %b mem_ready %b want %b %b 0",
                 k, if_ready, stall, mem_ready, (k == 3), (k != 3));
      end
    end
    checks++;
    if (if_rdata !== 16'h4A21) begin
      errors++;
      $display("FAIL fetch_data: got %h want 4a21", if_rdata);
    end
    if_req = 1'b0;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    mem_wr = 1'b1; mem_addr = 16'h8010; mem_wdata = 16'hBEEF;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== wr_seq[k-1] || mem_ready !== (k == 5)) begin
        errors++;
        $display("FAIL wr_strobe_c%0d: got %b ready %b want %b ready %b", k,
                 {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, mem_ready, wr_seq[k-1], (k == 5));
      end
      if (k < 5) begin
        checks++;
        if (sram_addr !== 18'h08010 || sram_dq_o !== 16'hBEEF) begin
          errors++;
          $display("FAIL wr_addr_data_c%0d: got %h %h want 08010 beef", k, sram_addr, sram_dq_o);
        end
      end
    end
    mem_wr = 1'b0;
    @(negedge clk);
    mem_rd = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k < 3) begin
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b0010) begin
          errors++;
          $display("FAIL rd_strobe_c%0d: got %b want 0010", k, {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe});
        end
      end
    end
    checks++;
    if (mem_ready !== 1'b1 || mem_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL rd_back: got ready %b data %h want 1 beef", mem_ready, mem_rdata);
    end
    mem_rd = 1'b0;
  endtask

  task automatic test_round_robin();
    logic exp_m, exp_i;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0020; mem_rd = 1'b1; mem_addr = 16'h0030;
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp_m = (k % 8 == 3);
      exp_i = (k % 8 == 7);
      checks++;
      if (mem_ready !== exp_m || if_ready !== exp_i || stall !== 1'b1) begin
        errors++;
        $display("FAIL rr_c%0d: got mem %b if %b stall %b want %b %b 1",
                 k, mem_ready, if_ready, stall, exp_m, exp_i);
      end
      if (exp_m) begin
        checks++;
        if (mem_rdata !== 16'h3030) begin
          errors++;
          $display("FAIL rr_mem_data_c%0d: got %h want 3030", k, mem_rdata);
        end
      end
      if (exp_i) begin
        checks++;
        if (if_rdata !== 16'h2020) begin
          errors++;
          $display("FAIL rr_if_data_c%0d: got %h want 2020", k, if_rdata);
        end
      end
    end
    if_req = 1'b0; mem_rd = 1'b0;
  endtask

  task automatic test_back_to_back();
    int unsigned idx;
    @(negedge clk);
    idx = 0;
    if_req0 = 1'b1; if_addr0 = 16'h0000;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      checks++;
      if (if_ready0 !== (k % 3 == 2)) begin
        errors++;
        $display("FAIL b2b_ready_c%0d: got %b want %b", k, if_ready0, (k % 3 == 2));
      end
      if (k % 3 == 2) begin
        checks++;
        if (if_rdata0 !== 16'hC0D0 + 16'(idx)) begin
          errors++;
          $display("FAIL b2b_data_%0d: got %h want %h", idx, if_rdata0, 16'hC0D0 + 16'(idx));
        end
        idx++;
        if_addr0 = 16'(idx);
        if (idx == 4) if_req0 = 1'b0;
      end
    end
  endtask

  task automatic test_rd_wr_both();
    @(negedge clk);
    mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 16'h0060; mem_wdata = 16'h5A5A;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== wr_seq[k-1] || mem_ready !== (k == 5)) begin
        errors++;
        $display("FAIL both_strobe_c%0d: got %b ready %b want %b ready %b", k,
                 {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, mem_ready, wr_seq[k-1], (k == 5));
      end
    end
    mem_rd = 1'b0; mem_wr = 1'b0;
    @(negedge clk);
    mem_rd = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_ready !== 1'b1 || mem_rdata !== 16'h5A5A) begin
      errors++;
      $display("FAIL both_readback: got ready %b data %h want 1 5a5a", mem_ready, mem_rdata);
    end
    mem_rd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_write();
    test_fetch();
    test_write_read();
    test_round_robin();
    test_back_to_back();
    test_rd_wr_both();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
